alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch-compare unit.
- Round-robin grant with valid/ready request handshakes.
- Drives the ALU operand and opcode inputs from the granted requester.
- Registers the ALU result, flags and the winning requester ID into a response slot with valid/ready backpressure.

Parameters:
- WORDSIZE, 32, operand and result width.
- OPSIZE, 4, opcode width. Opcodes 1–11 are ADD, SUB, SLL, SRL, SRA, SLU, SLT, OR, AND, XOR, SIU.
- NOP, 0, opcode driven to the ALU when no request is granted.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has an operation pending.
- REQ0_A  in  WORDSIZE  requester 0 operand A.
- REQ0_B  in  WORDSIZE  requester 0 operand B.
- REQ0_OP  in  OPSIZE  requester 0 opcode.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ1_VALID, REQ1_A, REQ1_B, REQ1_OP, REQ1_READY  same as port 0, for requester 1.
- ALU_A  out  WORDSIZE  operand A to ALU.
- ALU_B  out  WORDSIZE  operand B to ALU.
- ALU_OP  out  OPSIZE  opcode to ALU.
- ALU_OUT  in  WORDSIZE  ALU result, combinational from ALU_A/B/OP.
- ALU_C, ALU_V, ALU_Z, ALU_N  in  1 each  ALU flags.
- RSP_VALID  out  1  response slot holds a result.
- RSP_READY  in  1  consumer takes the response.
- RSP_ID  out  1  requester that issued the held result.
- RSP_OUT  out  WORDSIZE  registered result.
- RSP_FLAGS  out  4  registered flags, ordered {C,V,Z,N}.

Behaviour:
- Slot states: EMPTY (RSP_VALID=0) and FULL (RSP_VALID=1).
- can_accept = EMPTY, or (FULL and RSP_READY). A full slot being drained this cycle accepts a new result the same cycle, giving one op per cycle of throughput.
- Grant is combinational and evaluated only when can_accept=1:
  - Only one VALID high: that port wins.
  - Both high: the port not equal to LAST_GNT wins.
  - Neither high, or can_accept=0: no grant.
- READYn = grant to port n. At most one READY is high per cycle. READY never asserts without the matching VALID.
- Granted port: ALU_A/ALU_B/ALU_OP = that port's A/B/OP.
- No grant: ALU_A=0, ALU_B=0, ALU_OP=NOP.
- On the clock edge with a grant:
  - RSP_OUT ← ALU_OUT; RSP_FLAGS ← {ALU_C,ALU_V,ALU_Z,ALU_N}; RSP_ID ← granted port; LAST_GNT ← granted port; slot → FULL.
  - Latency is 1 cycle from the accept edge to RSP_VALID.
- Clock edge with FULL, RSP_READY=1 and no grant: slot → EMPTY. RSP_OUT, RSP_FLAGS and RSP_ID keep their stale values.
- FULL with RSP_READY=0: slot and all response fields hold. No READY asserts. Requesters must hold VALID and operands stable until READY; the arbiter does not latch unaccepted requests.
- Opcodes 0 and 12–15 are forwarded unchecked; the response carries whatever the ALU produces.
- Reset (synchronous, dominates all other inputs): RSP_VALID=0, RSP_ID=0, RSP_OUT=0, RSP_FLAGS=0, LAST_GNT=1 (port 0 wins the first tie).
  - A reset asserted while the slot is FULL discards the result without a handshake.
  - REQn_READY is forced to 0 during the reset cycle.
- Fairness: with both ports continuously valid and RSP_READY=1, grants alternate 0,1,0,1…; neither port waits more than one accepted op.

Test Plan:
- Reset, then REQ0 only, ADD A=5 B=7, RSP_READY=1 → REQ0_READY=1 that cycle; next cycle RSP_VALID=1, RSP_ID=0, RSP_OUT=12, RSP_FLAGS=0000.
- Both valid from reset, REQ0 SUB 3−3, REQ1 OR 0xF0|0x0F, RSP_READY=1, each port dropping VALID after its accept →
  - cycle 1: grant port 0; response RSP_ID=0, RSP_OUT=0, Z=1.
  - cycle 2: grant port 1; response RSP_ID=1, RSP_OUT=0xFF.
- Backpressure: slot FULL with RSP_READY=0 for 4 cycles while REQ1 holds XOR 0xAA^0xFF → REQ1_READY=0 throughout, RSP fields unchanged. Cycle with RSP_READY=1 → REQ1_READY=1; next cycle RSP_OUT=0x55, RSP_ID=1.
- Both ports continuously valid (ADD 1+1, SLL 1<<4) for 6 cycles, RSP_READY=1 → RSP_ID sequence 0,1,0,1,0,1 and RSP_OUT sequence 2,16,2,16,2,16.
- Flags pass-through: REQ0 ADD 0xFFFFFFFF+1 → RSP_OUT=0, RSP_FLAGS C=1, Z=1 (as reported by the ALU).
- Reset asserted while FULL and REQ0_VALID=1 → REQ0_READY=0 in the reset cycle; next cycle RSP_VALID=0, RSP_OUT=0. Tie on the following cycle goes to port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage
// (port 0) and the address/branch-compare unit (port 1), with a registered response slot.
module alu_arbiter #(
    parameter int                WORDSIZE = 32,
    parameter int                OPSIZE   = 4,
    parameter logic [OPSIZE-1:0] NOP      = '0
) (
    input  logic                CLK,
    input  logic                RST,

    input  logic                REQ0_VALID,
    input  logic [WORDSIZE-1:0] REQ0_A,
    input  logic [WORDSIZE-1:0] REQ0_B,
    input  logic [OPSIZE-1:0]   REQ0_OP,
    output logic                REQ0_READY,

    input  logic                REQ1_VALID,
    input  logic [WORDSIZE-1:0] REQ1_A,
    input  logic [WORDSIZE-1:0] REQ1_B,
    input  logic [OPSIZE-1:0]   REQ1_OP,
    output logic                REQ1_READY,

    output logic [WORDSIZE-1:0] ALU_A,
    output logic [WORDSIZE-1:0] ALU_B,
    output logic [OPSIZE-1:0]   ALU_OP,
    input  logic [WORDSIZE-1:0] ALU_OUT,
    input  logic                ALU_C,
    input  logic                ALU_V,
    input  logic                ALU_Z,
    input  logic                ALU_N,

    output logic                RSP_VALID,
    input  logic                RSP_READY,
    output logic                RSP_ID,
    output logic [WORDSIZE-1:0] RSP_OUT,
    output logic [3:0]          RSP_FLAGS
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t state;
    slot_state_t state_next;

    logic last_gnt;
    logic can_accept;
    logic gnt0;
    logic gnt1;
    logic gnt_any;

    // A full slot that is being drained this cycle can take a new result in
    // the same cycle, which is what sustains one op per cycle.
    assign can_accept = (state == SLOT_EMPTY) || RSP_READY;

    always_comb begin : arbitrate
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the if/else leaves a variable unassigned and infers a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST && can_accept) begin
            if (REQ0_VALID && REQ1_VALID) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = REQ0_VALID;
                gnt1 = REQ1_VALID;
            end
        end
    end

    assign gnt_any    = gnt0 || gnt1;
    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;

    always_comb begin : alu_drive
        ALU_A  = '0;
        ALU_B  = '0;
        ALU_OP = NOP;
        if (gnt0) begin
            ALU_A  = REQ0_A;
            ALU_B  = REQ0_B;
            ALU_OP = REQ0_OP;
        end else if (gnt1) begin
            ALU_A  = REQ1_A;
            ALU_B  = REQ1_B;
            ALU_OP = REQ1_OP;
        end
    end

    always_comb begin : slot_next
        state_next = state;
        if (gnt_any) begin
            state_next = SLOT_FULL;
        end else if (state == SLOT_FULL && RSP_READY) begin
            state_next = SLOT_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin : slot_reg
        // NOTE: sequential state is assigned with <= so every flop samples the
        // pre-edge values and the result does not depend on block ordering.
        if (RST) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign RSP_VALID = (state == SLOT_FULL);

    always_ff @(posedge CLK) begin : rsp_reg
        // NOTE: the response datapath is reset too, so a freshly reset slot
        // reads back zeros instead of whatever the flops powered up with.
        if (RST) begin
            RSP_OUT   <= '0;
            RSP_FLAGS <= '0;
            RSP_ID    <= 1'b0;
            last_gnt  <= 1'b1;
        end else if (gnt_any) begin
            RSP_OUT   <= ALU_OUT;
            RSP_FLAGS <= {ALU_C, ALU_V, ALU_Z, ALU_N};
            RSP_ID    <= gnt1;
            last_gnt  <= gnt1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios, then randomized traffic
// checked against a transaction-level model of the arbiter and an ALU model.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int O = 4;

    logic          CLK;
    logic          RST;
    logic          REQ0_VALID, REQ1_VALID;
    logic [W-1:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic [O-1:0]  REQ0_OP, REQ1_OP;
    logic          REQ0_READY, REQ1_READY;
    logic [W-1:0]  ALU_A, ALU_B, ALU_OUT;
    logic [O-1:0]  ALU_OP;
    logic          ALU_C, ALU_V, ALU_Z, ALU_N;
    logic          RSP_VALID, RSP_READY, RSP_ID;
    logic [W-1:0]  RSP_OUT;
    logic [3:0]    RSP_FLAGS;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [W-1:0] out;
        logic [3:0]   flags;
    } alu_res_t;

    typedef struct {
        bit           id;
        logic [W-1:0] out;
        logic [3:0]   flags;
    } exp_t;

    exp_t exp_q[$];

    alu_arbiter #(.WORDSIZE(W), .OPSIZE(O), .NOP('0)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_OP(REQ0_OP), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_OP(REQ1_OP), .REQ1_READY(REQ1_READY),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_OUT(ALU_OUT),
        .ALU_C(ALU_C), .ALU_V(ALU_V), .ALU_Z(ALU_Z), .ALU_N(ALU_N),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_OUT(RSP_OUT), .RSP_FLAGS(RSP_FLAGS)
    );

    // Behavioural ALU: both the stand-in for the real ALU and the source of expected results.
    function automatic alu_res_t alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [O-1:0] op);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        alu_res_t     res;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd1: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[W-1:0];
                c = wide[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd2: begin
                r = a - b;
                c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd3:    r = a << b[4:0];
            4'd4:    r = a >> b[4:0];
            4'd5:    r = $signed(a) >>> b[4:0];
            4'd6:    r = {31'b0, a < b};
            4'd7:    r = {31'b0, $signed(a) < $signed(b)};
            4'd8:    r = a | b;
            4'd9:    r = a & b;
            4'd10:   r = a ^ b;
            4'd11:   r = {b[15:0], 16'h0000};
            default: r = 32'hDEAD_0000 | {28'b0, op};
        endcase
        res.out   = r;
        res.flags = {c, v, (r == '0), r[W-1]};
        return res;
    endfunction

    alu_res_t alu_now;
    always_comb alu_now = alu_ref(ALU_A, ALU_B, ALU_OP);
    assign ALU_OUT = alu_now.out;
    assign {ALU_C, ALU_V, ALU_Z, ALU_N} = alu_now.flags;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: which port should win, and what it should return.
    bit m_full = 1'b0;
    bit m_last = 1'b1;

    initial begin : predictor
        int   win;
        exp_t e;
        alu_res_t r;
        forever begin
            @(negedge CLK);
            win = -1;
            if (!RST && (!m_full || RSP_READY)) begin
                if (REQ0_VALID && REQ1_VALID) win = 1 - int'(m_last);
                else if (REQ0_VALID)          win = 0;
                else if (REQ1_VALID)          win = 1;
            end
            check("rsp_valid", RSP_VALID, m_full);
            check("req0_ready", REQ0_READY, win == 0);
            check("req1_ready", REQ1_READY, win == 1);
            check("alu_a", ALU_A, win == 0 ? REQ0_A : win == 1 ? REQ1_A : '0);
            check("alu_b", ALU_B, win == 0 ? REQ0_B : win == 1 ? REQ1_B : '0);
            check("alu_op", ALU_OP, win == 0 ? REQ0_OP : win == 1 ? REQ1_OP : '0);
            if (RST) begin
                m_full = 1'b0;
                m_last = 1'b1;
                exp_q.delete();
            end else if (win >= 0) begin
                r = (win == 0) ? alu_ref(REQ0_A, REQ0_B, REQ0_OP) : alu_ref(REQ1_A, REQ1_B, REQ1_OP);
                e.id    = (win == 1);
                e.out   = r.out;
                e.flags = r.flags;
                exp_q.push_back(e);
                m_full = 1'b1;
                m_last = (win == 1);
            end else if (m_full && RSP_READY) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rsp_id", RSP_ID, e.id);
                    check("sb_rsp_out", RSP_OUT, e.out);
                    check("sb_rsp_flags", RSP_FLAGS, e.flags);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(int p, bit v, logic [W-1:0] a, logic [W-1:0] b, logic [O-1:0] op);
        if (p == 0) begin
            REQ0_VALID = v; REQ0_A = a; REQ0_B = b; REQ0_OP = op;
        end else begin
            REQ1_VALID = v; REQ1_A = a; REQ1_B = b; REQ1_OP = op;
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stimulus
        bit acc0;
        bit acc1;
        RST = 1'b1;
        RSP_READY = 1'b1;
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        step(); step();
        @(negedge CLK);
        check("reset_rsp_valid", RSP_VALID, 0);
        check("reset_rsp_out", RSP_OUT, 0);
        check("reset_rsp_id", RSP_ID, 0);
        check("reset_rsp_flags", RSP_FLAGS, 0);
        step();
        RST = 1'b0;

        // Single requester ADD 5+7.
        drive(0, 1, 5, 7, 4'd1);
        @(negedge CLK);
        check("t1_ready0", REQ0_READY, 1);
        check("t1_ready1", REQ1_READY, 0);
        step(); drive(0, 0, '0, '0, '0);
        @(negedge CLK);
        check("t1_rsp_valid", RSP_VALID, 1);
        check("t1_rsp_id", RSP_ID, 0);
        check("t1_rsp_out", RSP_OUT, 12);
        check("t1_rsp_flags", RSP_FLAGS, 4'b0000);
        step();

        // Tie straight out of reset goes to port 0, then port 1.
        RST = 1'b1; step(); RST = 1'b0;
        drive(0, 1, 3, 3, 4'd2);
        drive(1, 1, 32'hF0, 32'h0F, 4'd8);
        @(negedge CLK);
        check("t2_ready0", REQ0_READY, 1);
        check("t2_ready1_blocked", REQ1_READY, 0);
        step(); drive(0, 0, '0, '0, '0);
        @(negedge CLK);
        check("t2_ready1", REQ1_READY, 1);
        check("t2_rsp0_id", RSP_ID, 0);
        check("t2_rsp0_out", RSP_OUT, 0);
        check("t2_rsp0_flags", RSP_FLAGS, 4'b0010);
        step(); drive(1, 0, '0, '0, '0);
        @(negedge CLK);
        check("t2_rsp1_id", RSP_ID, 1);
        check("t2_rsp1_out", RSP_OUT, 32'hFF);
        step();
        @(negedge CLK);
        check("t2_drained", RSP_VALID, 0);
        check("t2_stale_out", RSP_OUT, 32'hFF);
        check("t2_stale_id", RSP_ID, 1);
        step();

        // Backpressure: full slot with RSP_READY low blocks port 1.
        RSP_READY = 1'b0;
        drive(0, 1, 1, 2, 4'd1);
        @(negedge CLK);
        check("t3_fill_ready0", REQ0_READY, 1);
        step(); drive(0, 0, '0, '0, '0);
        drive(1, 1, 32'hAA, 32'hFF, 4'd10);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t3_hold_ready1", REQ1_READY, 0);
            check("t3_hold_valid", RSP_VALID, 1);
            check("t3_hold_out", RSP_OUT, 3);
            check("t3_hold_id", RSP_ID, 0);
            step();
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        check("t3_release_ready1", REQ1_READY, 1);
        step(); drive(1, 0, '0, '0, '0);
        @(negedge CLK);
        check("t3_rsp_out", RSP_OUT, 32'h55);
        check("t3_rsp_id", RSP_ID, 1);
        step();

        // Both continuously valid: strict alternation.
        drive(0, 1, 1, 1, 4'd1);
        drive(1, 1, 1, 4, 4'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("t4_ready0", REQ0_READY, (i % 2) == 0);
            if (i > 0) begin
                check("t4_rsp_id", RSP_ID, (i - 1) % 2);
                check("t4_rsp_out", RSP_OUT, ((i - 1) % 2) ? 16 : 2);
            end
            step();
        end
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        @(negedge CLK);
        check("t4_last_id", RSP_ID, 1);
        check("t4_last_out", RSP_OUT, 16);
        step();

        // Carry and zero flags from the ALU pass straight through.
        drive(0, 1, 32'hFFFF_FFFF, 1, 4'd1);
        @(negedge CLK);
        check("t5_ready0", REQ0_READY, 1);
        step(); drive(0, 0, '0, '0, '0);
        @(negedge CLK);
        check("t5_rsp_out", RSP_OUT, 0);
        check("t5_rsp_flags", RSP_FLAGS, 4'b1010);
        step();

        // Reset while full discards the result; the next tie goes to port 0.
        RSP_READY = 1'b0;
        drive(0, 1, 2, 2, 4'd1);
        @(negedge CLK);
        check("t6_fill_ready0", REQ0_READY, 1);
        step();
        drive(0, 1, 9, 9, 4'd1);
        RST = 1'b1;
        RSP_READY = 1'b1;
        @(negedge CLK);
        check("t6_rst_ready0", REQ0_READY, 0);
        check("t6_rst_alu_op", ALU_OP, 0);
        step();
        RST = 1'b0;
        drive(1, 1, 5, 5, 4'd10);
        @(negedge CLK);
        check("t6_post_valid", RSP_VALID, 0);
        check("t6_post_out", RSP_OUT, 0);
        check("t6_post_flags", RSP_FLAGS, 0);
        check("t6_tie_ready0", REQ0_READY, 1);
        check("t6_tie_ready1", REQ1_READY, 0);
        step(); drive(0, 0, '0, '0, '0);
        @(negedge CLK);
        check("t6_next_ready1", REQ1_READY, 1);
        step(); drive(1, 0, '0, '0, '0);
        step(); step();

        // Randomized traffic; requesters hold requests until accepted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            acc0 = REQ0_READY;
            acc1 = REQ1_READY;
            step();
            RST = ($urandom_range(0, 299) == 0);
            RSP_READY = ($urandom_range(0, 9) < 7);
            if (!REQ0_VALID || acc0)
                drive(0, $urandom_range(0, 3) != 0, rand_word(), rand_word(), O'($urandom_range(0, 15)));
            if (!REQ1_VALID || acc1)
                drive(1, $urandom_range(0, 3) != 0, rand_word(), rand_word(), O'($urandom_range(0, 15)));
        end

        RST = 1'b0;
        RSP_READY = 1'b1;
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        repeat (4) step();
        @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
